reg_dump_ctrl: RTL and testbench
================================

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 Parameter FIRST_REG, default 0: first register index dumped (0..31).
REQ-002 Parameter LAST_REG, default 31: last register index dumped (FIRST_REG..31).
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a dump.
REQ-006 abort  input  1  cancels a dump in progress.
REQ-007 ReadReg  output  5  register-file read-port address.
REQ-008 ReadData  input  32  register-file read data, combinational from ReadReg.
REQ-009 out_valid  output  1  out_data/out_index/out_last valid.
REQ-010 out_ready  input  1  consumer accepts the word when out_valid is high.
REQ-011 out_data  output  32  dumped word.
REQ-012 out_index  output  5  register index of out_data.
REQ-013 out_last  output  1  final word of the dump.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-016 FSM states: IDLE, LOAD, SEND, CHK (CHK only with REG_DUMP_CHKSUM_EN).
REQ-017 IDLE: start=1 and abort=0 -> idx<=FIRST_REG, go LOAD; otherwise stay.
REQ-018 ReadReg equals idx in all states; idx holds its value in IDLE.
REQ-019 LOAD: capture ReadData into out_data, idx into out_index; set out_valid=1; go SEND.
REQ-020 SEND: out_valid stays 1 and out_data/out_index/out_last stay stable until out_valid&&out_ready is sampled.
REQ-021 SEND accept with idx<LAST_REG: out_valid<=0, idx<=idx+1, go LOAD.
REQ-022 SEND accept with idx==LAST_REG: go CHK if enabled, else IDLE with done=1 for one cycle.
REQ-023 out_last is 1 with the LAST_REG word only when the checksum is disabled; otherwise only with the checksum word.
REQ-024 Throughput: at most one word per 2 cycles; first out_valid 2 cycles after start is sampled.
REQ-025 start while busy is ignored.
REQ-026 abort=1 in LOAD/SEND/CHK -> IDLE next cycle, out_valid<=0, no done pulse; if abort coincides with an accept, abort wins.
REQ-027 start and abort both high in IDLE -> stay IDLE.
REQ-028 FIRST_REG==LAST_REG dumps exactly one register word.
REQ-029 Register 0 reads through the register file as 0; it is dumped as returned, with no special-casing.

Reset
REQ-030 RST low forces IDLE, idx=FIRST_REG, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, checksum=0, at once, regardless of CLK.
REQ-031 Reset mid-dump discards the dump; the next dump requires a new start.

Configuration
REQ-032 Macro REG_DUMP_CHKSUM_EN defined: the dump appends one word, the XOR of all dumped words, with out_index=0 and out_last=1, presented with the same valid/ready rules; the checksum clears when a dump starts.
REQ-033 Macro REG_DUMP_CHKSUM_EN undefined: there is no CHK state or checksum register, and the dump ends after the LAST_REG word.

Verification
REQ-034 Regfile preloaded with reg[i]=i*0x11111111, out_ready=1, start pulse -> 32 words, index 0..31, data matching, out_last on word 31, done pulsed once.
REQ-035 out_ready held low for 5 cycles on word 3 -> out_valid held high and out_data=0x33333333 stable; word 4 only after acceptance.
REQ-036 abort during SEND of word 10 -> out_valid=0 next cycle, busy=0, no done; a following start restarts from index 0.
REQ-037 RST asserted low in LOAD between clock edges -> all outputs 0 immediately; start after release gives a full dump.
REQ-038 REG_DUMP_CHKSUM_EN with reg[1]=0xA5A5A5A5, reg[2]=0x0F0F0F0F, others 0 -> 33rd word 0xAAAAAAAA, index 0, out_last=1.
REQ-039 FIRST_REG=LAST_REG=5, reg[5]=0xDEADBEEF -> a single word 0xDEADBEEF, out_last=1, done pulse.

Source files
------------

// File: rtl/reg_dump_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_dump_ctrl_if : register-file read port plus valid/ready dump stream.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface reg_dump_ctrl_if;
    logic [4:0]  ReadReg;
    logic [31:0] ReadData;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;

    modport master (
        output ReadReg,
        input  ReadData,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index,
        output out_last
    );

    modport slave (
        input  ReadReg,
        output ReadData,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index,
        input  out_last
    );
endinterface
`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_dump_ctrl : streams registers FIRST_REG..LAST_REG out over valid/ready.|
// | Optional macro REG_DUMP_CHKSUM_EN appends an XOR checksum word.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module reg_dump_ctrl #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    input  wire logic        start,
    input  wire logic        abort,
    output logic             busy,
    output logic             done,
    reg_dump_ctrl_if.master  bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_SEND = 2'd2;
`ifdef REG_DUMP_CHKSUM_EN
    localparam logic [1:0] c_CHK  = 2'd3;
`endif

    localparam logic [4:0] c_FIRST = 5'(FIRST_REG);
    localparam logic [4:0] c_LAST  = 5'(LAST_REG);

    logic [1:0]  r_state;
    logic [4:0]  r_idx;
    logic        r_outValid;
    logic [31:0] r_outData;
    logic [4:0]  r_outIndex;
    logic        r_outLast;
    logic        r_done;
`ifdef REG_DUMP_CHKSUM_EN
    logic [31:0] r_chksum;
`endif

    logic w_isLast;
    logic w_accept;

    assign w_isLast = (r_idx == c_LAST);
    assign w_accept = r_outValid && bus.out_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= c_IDLE;
            r_idx      <= c_FIRST;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outIndex <= '0;
            r_outLast  <= 1'b0;
            r_done     <= 1'b0;
`ifdef REG_DUMP_CHKSUM_EN
            r_chksum   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start && !abort) begin
                        r_idx   <= c_FIRST;
                        r_state <= c_LOAD;
`ifdef REG_DUMP_CHKSUM_EN
                        r_chksum <= '0;
`endif
                    end
                end
                c_LOAD: begin
                    if (abort) begin
                        r_state    <= c_IDLE;
                        r_outValid <= 1'b0;
                    end else begin
                        r_outData  <= bus.ReadData;
                        r_outIndex <= r_idx;
                        r_outValid <= 1'b1;
                        r_state    <= c_SEND;
`ifdef REG_DUMP_CHKSUM_EN
                        // The checksum word carries out_last instead.
                        r_outLast  <= 1'b0;
                        r_chksum   <= r_chksum ^ bus.ReadData;
`else
                        r_outLast  <= w_isLast;
`endif
                    end
                end
                c_SEND: begin
                    // Abort takes priority over a coincident accept.
                    if (abort) begin
                        r_state    <= c_IDLE;
                        r_outValid <= 1'b0;
                    end else if (w_accept) begin
                        r_outValid <= 1'b0;
                        if (!w_isLast) begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= c_LOAD;
                        end else begin
`ifdef REG_DUMP_CHKSUM_EN
                            r_state <= c_CHK;
`else
                            r_state <= c_IDLE;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef REG_DUMP_CHKSUM_EN
                c_CHK: begin
                    // First cycle presents the checksum, later cycles wait for accept.
                    if (abort) begin
                        r_state    <= c_IDLE;
                        r_outValid <= 1'b0;
                    end else if (!r_outValid) begin
                        r_outData  <= r_chksum;
                        r_outIndex <= '0;
                        r_outLast  <= 1'b1;
                        r_outValid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= c_IDLE;
                        r_done     <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state    <= c_IDLE;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = (r_state != c_IDLE);
    assign done          = r_done;
    assign bus.ReadReg   = r_idx;
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_index = r_outIndex;
    assign bus.out_last  = r_outLast;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_dump_ctrl : directed bench for reg_dump_ctrl (full range and 5..5). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_reg_dump_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        start5 = 1'b0;
    logic        abort5 = 1'b0;
    logic        busy5;
    logic        done5;
    logic [31:0] rf  [32];
    logic [31:0] rf5 [32];
    int          nCompared   = 0;
    int          nMismatched = 0;
    int          doneCnt     = 0;
    int          doneBefore;

    reg_dump_ctrl_if bus ();
    reg_dump_ctrl_if bus5 ();

    assign bus.ReadData  = rf[bus.ReadReg];
    assign bus5.ReadData = rf5[bus5.ReadReg];

    reg_dump_ctrl #(.FIRST_REG(0), .LAST_REG(31)) u_dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .busy(busy), .done(done), .bus(bus)
    );

    reg_dump_ctrl #(.FIRST_REG(5), .LAST_REG(5)) u_dut5 (
        .CLK(CLK), .RST(RST), .start(start5), .abort(abort5),
        .busy(busy5), .done(done5), .bus(bus5)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (done) doneCnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic waitValid(input string tag);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic expectWord(input string tag, input logic [31:0] d, input logic [4:0] ix, input logic lst);
        check({tag, "_data"},  bus.out_data, d);
        check({tag, "_index"}, 32'(bus.out_index), 32'(ix));
        check({tag, "_last"},  32'(bus.out_last), 32'(lst));
    endtask

    // Full dump 0..31; optional 5-cycle stall on one word or abort on one word.
    task automatic runDump(input int stallWord, input int abortWord);
        logic [31:0] cs;
        logic        lastFlag;
        cs = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_noValid", 32'(bus.out_valid), 32'd0);
        tick();
        check("first_latency", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 32; i++) begin
            waitValid("word");
            if (i == abortWord) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_valid", 32'(bus.out_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                return;
            end
`ifdef REG_DUMP_CHKSUM_EN
            lastFlag = 1'b0;
`else
            lastFlag = (i == 31);
`endif
            if (i == stallWord) begin
                bus.out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    if (k == 2) start = 1'b1;
                    tick();
                    start = 1'b0;
                    check("stall_valid", 32'(bus.out_valid), 32'd1);
                    expectWord("stall", rf[i], 5'(i), lastFlag);
                end
                bus.out_ready = 1'b1;
            end
            cs ^= rf[i];
            expectWord("word", rf[i], 5'(i), lastFlag);
            tick();
            check("gap_noValid", 32'(bus.out_valid), 32'd0);
        end
`ifdef REG_DUMP_CHKSUM_EN
        waitValid("chksum");
        expectWord("chksum", cs, 5'd0, 1'b1);
        tick();
`endif
        check("done_pulse", 32'(done), 32'd1);
        check("done_idle", 32'(busy), 32'd0);
        tick();
        check("done_low", 32'(done), 32'd0);
    endtask

    initial begin
        bus.out_ready  = 1'b1;
        bus5.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rf[i]  = i * 32'h1111_1111;
            rf5[i] = 32'(i);
        end
        rf5[5] = 32'hDEAD_BEEF;

        #12;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_readReg", 32'(bus.ReadReg), 32'd0);
        check("rst_readReg5", 32'(bus5.ReadReg), 32'd5);
        RST = 1'b1;
        tick();

        // start and abort together in IDLE: no dump.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("startAbort_idle", 32'(busy), 32'd0);

        runDump(-1, -1);
        check("doneCnt_full", 32'(doneCnt), 32'd1);

        runDump(3, -1);
        check("stall_word3_const", rf[3], 32'h3333_3333);

        doneBefore = doneCnt;
        runDump(-1, 10);
        repeat (3) tick();
        check("abort_noDone", 32'(doneCnt), 32'(doneBefore));
        check("abort_stayIdle", 32'(busy), 32'd0);
        runDump(-1, -1);

        // Reset asserted between edges while in LOAD after word 2.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            waitValid("pre");
            tick();
        end
        check("pre_busy", 32'(busy), 32'd1);
        check("pre_data", bus.out_data, 32'h2222_2222);
        #2 RST = 1'b0;
        #1;
        check("asyncRst_busy", 32'(busy), 32'd0);
        check("asyncRst_data", bus.out_data, 32'd0);
        check("asyncRst_index", 32'(bus.out_index), 32'd0);
        check("asyncRst_last", 32'(bus.out_last), 32'd0);
        check("asyncRst_valid", 32'(bus.out_valid), 32'd0);
        check("asyncRst_readReg", 32'(bus.ReadReg), 32'd0);
        #3 RST = 1'b1;
        tick();
        tick();
        check("postRst_idle", 32'(busy), 32'd0);
        runDump(-1, -1);

`ifdef REG_DUMP_CHKSUM_EN
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[1] = 32'hA5A5_A5A5;
        rf[2] = 32'h0F0F_0F0F;
        runDump(-1, -1);
`endif

        // Single-register dump on the FIRST_REG=LAST_REG=5 instance.
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        tick();
        check("one_valid", 32'(bus5.out_valid), 32'd1);
        check("one_data", bus5.out_data, 32'hDEAD_BEEF);
        check("one_index", 32'(bus5.out_index), 32'd5);
`ifdef REG_DUMP_CHKSUM_EN
        check("one_last", 32'(bus5.out_last), 32'd0);
        tick();
        tick();
        check("one_cs_valid", 32'(bus5.out_valid), 32'd1);
        check("one_cs_data", bus5.out_data, 32'hDEAD_BEEF);
        check("one_cs_index", 32'(bus5.out_index), 32'd0);
        check("one_cs_last", 32'(bus5.out_last), 32'd1);
`else
        check("one_last", 32'(bus5.out_last), 32'd1);
`endif
        tick();
        check("one_done", 32'(done5), 32'd1);
        check("one_idle", 32'(busy5), 32'd0);
        tick();
        check("one_doneLow", 32'(done5), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
